// File: rtl/tpg_monitor_pkg.sv
// Shared types and constants for the TPG output monitor.
package tpg_monitor_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRAIN  = 2'd1,
    CHECK  = 2'd2
  } state_t;

  localparam int ERR_HTOT = 0;
  localparam int ERR_HSW  = 1;
  localparam int ERR_ACTW = 2;
  localparam int ERR_VTOT = 3;
  localparam int ERR_ACTL = 4;
  localparam int ERR_PIX  = 5;
  localparam int ERR_BITS = 6;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tpg_span_meas.sv
// Saturating span counter: counts enabled cycles between start events and
// presents the finished span, including the start cycle itself, on start.
module tpg_span_meas #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         count_en,
  output logic [W-1:0] value,
  output logic         valid
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_inc;
  logic         armed;

  assign cnt_inc = (&cnt) ? cnt : cnt + W'(1);
  assign value   = count_en ? cnt_inc : cnt;
  // The first start after reset only opens a span; the partial one is dropped.
  assign valid   = start & armed;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (start) begin
      cnt   <= '0;
      armed <= 1'b1;
    end else if (count_en) begin
      cnt   <= cnt_inc;
    end
  end

endmodule

// File: rtl/tpg_monitor.sv
// Passive checker on the TPG video output: measures line/frame timing,
// compares it against programmed values and checks the grey-ramp pattern.
module tpg_monitor
  import tpg_monitor_pkg::*;
#(
  parameter int PW     = 8,
  parameter int H_BITS = 12,
  parameter int V_BITS = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hs,
  input  logic                vs,
  input  logic                vld,
  input  logic [3*PW-1:0]     rgb,
  input  logic [H_BITS-1:0]   exp_h_total,
  input  logic [H_BITS-1:0]   exp_hs_width,
  input  logic [H_BITS-1:0]   exp_act_width,
  input  logic [V_BITS-1:0]   exp_v_total,
  input  logic [V_BITS-1:0]   exp_act_lines,
  input  logic                clr_err,
  output logic                locked,
  output logic [H_BITS-1:0]   meas_h_total,
  output logic [H_BITS-1:0]   meas_hs_width,
  output logic [H_BITS-1:0]   meas_act_width,
  output logic [V_BITS-1:0]   meas_v_total,
  output logic [V_BITS-1:0]   meas_act_lines,
  output logic [ERR_BITS-1:0] err_flags,
  output logic [15:0]         err_cnt,
  output logic [15:0]         frame_cnt
);

  state_t state;

  logic hs_d, vs_d, vld_d;
  logic hs_rise, hs_fall, vs_rise, vld_fall;

  assign hs_rise  = hs & ~hs_d;
  assign hs_fall  = ~hs & hs_d;
  assign vs_rise  = vs & ~vs_d;
  assign vld_fall = ~vld & vld_d;

  logic [H_BITS-1:0] htot_val, hsw_val, actw_val;
  logic              htot_vld, hsw_vld, actw_vld;

  tpg_span_meas #(.W(H_BITS)) u_htot (
    .clk(clk), .rst(rst), .start(hs_rise), .count_en(1'b1),
    .value(htot_val), .valid(htot_vld)
  );

  tpg_span_meas #(.W(H_BITS)) u_hsw (
    .clk(clk), .rst(rst), .start(hs_fall), .count_en(hs),
    .value(hsw_val), .valid(hsw_vld)
  );

  tpg_span_meas #(.W(H_BITS)) u_actw (
    .clk(clk), .rst(rst), .start(vld_fall), .count_en(vld),
    .value(actw_val), .valid(actw_vld)
  );

  // Vertical counters; values already include an hs rise landing this cycle.
  logic [V_BITS-1:0] vcnt, act_cnt;
  logic [V_BITS-1:0] vtot_val, actl_val;
  logic              line_act, v_armed, vtot_vld;

  assign vtot_val = (hs_rise && !(&vcnt)) ? vcnt + V_BITS'(1) : vcnt;
  assign actl_val = (hs_rise && line_act && !(&act_cnt)) ? act_cnt + V_BITS'(1) : act_cnt;
  assign vtot_vld = vs_rise & v_armed;

  logic [PW-1:0] pix_r, pix_g, pix_b, ref_pix, ref_next;
  logic          ref_vld, pix_bad;

  assign pix_r    = rgb[3*PW-1:2*PW];
  assign pix_g    = rgb[2*PW-1:PW];
  assign pix_b    = rgb[PW-1:0];
  assign ref_next = ref_pix + PW'(1);
  assign pix_bad  = (pix_r != pix_g) || (pix_g != pix_b) || (pix_r != ref_next);

  logic [ERR_BITS-1:0] new_err;
  logic                meas_fail;

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    new_err = '0;
    if (state == CHECK) begin
      new_err[ERR_HTOT] = htot_vld && (htot_val != exp_h_total);
      new_err[ERR_HSW]  = hsw_vld  && (hsw_val  != exp_hs_width);
      new_err[ERR_ACTW] = actw_vld && (actw_val != exp_act_width);
      new_err[ERR_VTOT] = vtot_vld && (vtot_val != exp_v_total);
      new_err[ERR_ACTL] = vtot_vld && (actl_val != exp_act_lines);
      new_err[ERR_PIX]  = vld && ref_vld && pix_bad;
    end
  end

  // Pixel errors are reported but never drop lock.
  assign meas_fail = |new_err[ERR_ACTL:ERR_HTOT];

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_d           <= 1'b0;
      vs_d           <= 1'b0;
      vld_d          <= 1'b0;
      vcnt           <= '0;
      act_cnt        <= '0;
      line_act       <= 1'b0;
      v_armed        <= 1'b0;
      meas_h_total   <= '0;
      meas_hs_width  <= '0;
      meas_act_width <= '0;
      meas_v_total   <= '0;
      meas_act_lines <= '0;
      frame_cnt      <= '0;
    end else begin
      hs_d     <= hs;
      vs_d     <= vs;
      vld_d    <= vld;
      line_act <= hs_rise ? vld : (line_act | vld);
      if (vs_rise) begin
        v_armed <= 1'b1;
        vcnt    <= hs_rise ? V_BITS'(1) : '0;
        act_cnt <= '0;
      end else begin
        vcnt    <= vtot_val;
        act_cnt <= actl_val;
      end
      if (htot_vld) meas_h_total   <= htot_val;
      if (hsw_vld)  meas_hs_width  <= hsw_val;
      if (actw_vld) meas_act_width <= actw_val;
      if (vtot_vld) begin
        meas_v_total   <= vtot_val;
        meas_act_lines <= actl_val;
      end
      frame_cnt <= frame_cnt + 16'(vs_rise);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SEARCH;
      locked <= 1'b0;
    end else begin
      case (state)
        SEARCH: if (vs_rise) state <= TRAIN;
        TRAIN: begin
          if (vs_rise) begin
            state  <= CHECK;
            locked <= 1'b1;
          end
        end
        CHECK: begin
          if (meas_fail) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // The first pixel seen in CHECK seeds the reference; every later pixel reloads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_pix <= '0;
      ref_vld <= 1'b0;
    end else if (state != CHECK) begin
      ref_vld <= 1'b0;
    end else if (vld) begin
      ref_pix <= pix_r;
      ref_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_flags <= '0;
      err_cnt   <= '0;
    end else begin
      err_flags <= (clr_err ? '0 : err_flags) | new_err;
      if (|new_err)     err_cnt <= clr_err ? 16'd1 : sat_inc16(err_cnt);
      else if (clr_err) err_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_tpg_monitor.sv
// Directed frame sequences with randomized pattern seed, stretch line and
// glitch position, checked against a frame-level expectation model.
module tb_tpg_monitor;

  localparam int PW     = 8;
  localparam int H_BITS = 12;
  localparam int V_BITS = 12;

  logic              clk = 1'b0;
  logic              rst, hs, vs, vld, clr_err;
  logic [3*PW-1:0]   rgb;
  logic [H_BITS-1:0] exp_h_total, exp_hs_width, exp_act_width;
  logic [V_BITS-1:0] exp_v_total, exp_act_lines;
  logic              locked;
  logic [H_BITS-1:0] meas_h_total, meas_hs_width, meas_act_width;
  logic [V_BITS-1:0] meas_v_total, meas_act_lines;
  logic [5:0]        err_flags;
  logic [15:0]       err_cnt, frame_cnt;

  tpg_monitor #(.PW(PW), .H_BITS(H_BITS), .V_BITS(V_BITS)) dut (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .vld(vld), .rgb(rgb),
    .exp_h_total(exp_h_total), .exp_hs_width(exp_hs_width),
    .exp_act_width(exp_act_width), .exp_v_total(exp_v_total),
    .exp_act_lines(exp_act_lines), .clr_err(clr_err), .locked(locked),
    .meas_h_total(meas_h_total), .meas_hs_width(meas_hs_width),
    .meas_act_width(meas_act_width), .meas_v_total(meas_v_total),
    .meas_act_lines(meas_act_lines), .err_flags(err_flags),
    .err_cnt(err_cnt), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   pix_val, pix_idx, bad_idx;
  int   frames, lock_rises;
  logic last_vs;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  function automatic logic [31:0] locked_exp();
    return 32'(lock_rises >= 2);
  endfunction

  // One clock of ideal-driver output; the grey ramp continues across lines and frames.
  task automatic drive(input logic h, input logic v, input logic d);
    logic [PW-1:0] p;
    hs  = h;
    vs  = v;
    vld = d;
    rgb = '0;
    if (d) begin
      p   = PW'(pix_val);
      rgb = {p, p, (pix_idx == bad_idx) ? PW'(p + 1) : p};
      pix_val = (pix_val + 1) % 256;
      pix_idx++;
    end
    if (v && !last_vs) begin
      frames++;
      lock_rises++;
    end
    last_vs = v;
    step();
  endtask

  // Line l of an 8-line frame, cycles c_lo..c_hi; lines 2..6 carry pixels.
  task automatic run_line(input int l, input int c_lo, input int c_hi, input bit early_vs);
    for (int c = c_lo; c <= c_hi; c++)
      drive(c < 4, (l == 0) && (early_vs || c >= 1), (l >= 2 && l <= 6) && c >= 6 && c < 16);
  endtask

  task automatic run_lines(input int lo, input int hi);
    for (int l = lo; l <= hi; l++) run_line(l, 0, 19, 1'b0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_locked"},    32'(locked),         32'd0);
    check({tag, "_h_total"},   32'(meas_h_total),   32'd0);
    check({tag, "_hs_width"},  32'(meas_hs_width),  32'd0);
    check({tag, "_act_width"}, 32'(meas_act_width), 32'd0);
    check({tag, "_v_total"},   32'(meas_v_total),   32'd0);
    check({tag, "_act_lines"}, 32'(meas_act_lines), 32'd0);
    check({tag, "_flags"},     32'(err_flags),      32'd0);
    check({tag, "_err_cnt"},   32'(err_cnt),        32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt),      32'd0);
  endtask

  initial begin
    int k, j, m;
    rst = 1'b1; hs = 1'b0; vs = 1'b0; vld = 1'b0; rgb = '0; clr_err = 1'b0;
    exp_h_total = 20; exp_hs_width = 4; exp_act_width = 10;
    exp_v_total = 8;  exp_act_lines = 5;
    last_vs = 1'b0; bad_idx = -1; pix_idx = 0; frames = 0; lock_rises = 0;
    pix_val = $urandom_range(0, 255);
    step();
    step();
    check_cleared("reset");
    rst = 1'b0;

    // Frames 0..2: lock after the second vs rise, then clean measurements.
    run_line(0, 0, 1, 1'b0);
    check("locked_after_vs1", 32'(locked), locked_exp());
    run_line(0, 2, 19, 1'b0);
    run_lines(1, 7);
    run_line(0, 0, 0, 1'b0);
    check("locked_before_vs2", 32'(locked), 32'd0);
    run_line(0, 1, 1, 1'b0);
    check("locked_after_vs2", 32'(locked), locked_exp());
    run_line(0, 2, 19, 1'b0);
    run_lines(1, 7);
    run_lines(0, 7);
    check("ideal_h_total",   32'(meas_h_total),   32'd20);
    check("ideal_hs_width",  32'(meas_hs_width),  32'd4);
    check("ideal_act_width", 32'(meas_act_width), 32'd10);
    check("ideal_v_total",   32'(meas_v_total),   32'd8);
    check("ideal_act_lines", 32'(meas_act_lines), 32'd5);
    check("ideal_flags",     32'(err_flags),      32'd0);
    check("ideal_err_cnt",   32'(err_cnt),        32'd0);
    check("ideal_frame_cnt", 32'(frame_cnt),      32'(frames));
    check("ideal_locked",    32'(locked),         locked_exp());

    // Frame 3: one 21-cycle line drops lock.
    k = $urandom_range(1, 6);
    run_lines(0, k - 1);
    run_line(k, 0, 20, 1'b0);
    run_line(k + 1, 0, 0, 1'b0);
    lock_rises = 0;
    check("stretch_h_total", 32'(meas_h_total), 32'd21);
    check("stretch_flags",   32'(err_flags),    32'h01);
    check("stretch_err_cnt", 32'(err_cnt),      32'd1);
    check("stretch_locked",  32'(locked),       locked_exp());
    run_line(k + 1, 1, 19, 1'b0);
    run_lines(k + 2, 7);

    // Frames 4, 5: relock two vs rises later.
    run_line(0, 0, 1, 1'b0);
    check("relock_train", 32'(locked), locked_exp());
    run_line(0, 2, 19, 1'b0);
    run_lines(1, 7);
    run_line(0, 0, 1, 1'b0);
    check("relock_check", 32'(locked), 32'd1);
    run_line(0, 2, 19, 1'b0);

    run_line(1, 0, 9, 1'b0);
    clr_err = 1'b1;
    run_line(1, 10, 10, 1'b0);
    clr_err = 1'b0;
    check("clr_flags",   32'(err_flags), 32'd0);
    check("clr_err_cnt", 32'(err_cnt),   32'd0);
    run_line(1, 11, 19, 1'b0);
    run_lines(2, 2);

    // One pixel with a mismatched blue component.
    j = $urandom_range(0, 8);
    bad_idx = pix_idx + j;
    run_line(3, 0, 6 + j, 1'b0);
    check("pix_flags",   32'(err_flags), 32'h20);
    check("pix_err_cnt", 32'(err_cnt),   32'd1);
    check("pix_locked",  32'(locked),    32'd1);
    run_line(3, 7 + j, 7 + j, 1'b0);
    bad_idx = -1;
    check("pix_resync_err_cnt", 32'(err_cnt),   32'd1);
    check("pix_resync_flags",   32'(err_flags), 32'h20);
    run_line(3, 8 + j, 19, 1'b0);
    run_lines(4, 7);
    check("pix_frame_locked", 32'(locked), 32'd1);

    // Frame 6: clr_err coincides with a failing hs_width compare.
    m = $urandom_range(1, 7);
    run_lines(0, m - 1);
    run_line(m, 0, 3, 1'b0);
    exp_hs_width = H_BITS'(4 + $urandom_range(1, 3));
    clr_err = 1'b1;
    run_line(m, 4, 4, 1'b0);
    exp_hs_width = 4;
    clr_err = 1'b0;
    lock_rises = 0;
    check("clrhit_flags",   32'(err_flags), 32'h02);
    check("clrhit_err_cnt", 32'(err_cnt),   32'd1);
    check("clrhit_locked",  32'(locked),    locked_exp());
    run_line(m, 5, 19, 1'b0);
    run_lines(m + 1, 7);

    // Frames 7, 8: relock, then reset mid-line.
    run_lines(0, 7);
    run_line(0, 0, 1, 1'b0);
    check("pre_rst_locked", 32'(locked), locked_exp());
    run_line(0, 2, 19, 1'b0);
    run_lines(1, 2);
    run_line(3, 0, 9, 1'b0);
    rst = 1'b1;
    run_line(3, 10, 10, 1'b0);
    rst = 1'b0;
    lock_rises = 0;
    frames = 0;
    check_cleared("midrst");
    run_line(3, 11, 19, 1'b0);
    run_line(4, 0, 0, 1'b0);
    check("rst_partial_h_total", 32'(meas_h_total), 32'd0);
    run_line(4, 1, 19, 1'b0);
    run_line(5, 0, 0, 1'b0);
    check("rst_first_h_total", 32'(meas_h_total), 32'd20);
    run_line(5, 1, 19, 1'b0);
    run_lines(6, 7);

    // Frames 9, 10 relock; frame 11 starts with vs and hs rising together.
    run_lines(0, 7);
    run_lines(0, 7);
    run_line(0, 0, 0, 1'b1);
    check("coinc_v_total",   32'(meas_v_total),   32'd8);
    check("coinc_act_lines", 32'(meas_act_lines), 32'd5);
    check("coinc_flags",     32'(err_flags),      32'd0);
    check("coinc_err_cnt",   32'(err_cnt),        32'd0);
    check("coinc_locked",    32'(locked),         locked_exp());
    check("coinc_frame_cnt", 32'(frame_cnt),      32'(frames));
    run_line(0, 1, 19, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
